// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the RAM/IO bus arbiter: FSM encodings, access length codes,
// IO region tag, bus widths and the length-normalising helper.
package ram_arbiter_pkg;

   localparam int MEM_ADDR_BUS = 32;
   localparam int MEM_DATA_BUS = 32;

   typedef logic [2:0] arb_state_t;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_IF_RD  = 3'd1;
   localparam logic [2:0] ST_MEM_RD = 3'd2;
   localparam logic [2:0] ST_MEM_WR = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam logic [2:0] LEN_B = 3'd1;
   localparam logic [2:0] LEN_H = 3'd2;
   localparam logic [2:0] LEN_W = 3'd4;

   localparam logic [1:0] IO_REGION = 2'b11;

   localparam logic OWNER_IF  = 1'b0;
   localparam logic OWNER_MEM = 1'b1;

   // Anything other than a byte or halfword request is carried out as a full word.
   function automatic logic [2:0] norm_len(input logic [2:0] len);
      logic [2:0] res;
      case (len)
         LEN_B:   res = LEN_B;
         LEN_H:   res = LEN_H;
         default: res = LEN_W;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/ram_arbiter_extend.sv
// Combinational load extender: byte and halfword results are sign- or zero-extended,
// word results pass straight through.
module ram_arbiter_extend
   import ram_arbiter_pkg::*;
#(
   parameter int DATA_W = MEM_DATA_BUS
) (
   input  logic [DATA_W-1:0] raw,
   input  logic [2:0]        len,
   input  logic              sgn,
   output logic [DATA_W-1:0] result
);

   // pick the extension source bit from the access length
   always_comb begin
      result = raw;
      case (len)
         LEN_B:   result = {{(DATA_W-8){sgn & raw[7]}}, raw[7:0]};
         LEN_H:   result = {{(DATA_W-16){sgn & raw[15]}}, raw[15:0]};
         default: result = raw;
      endcase
   end

endmodule

// File: rtl/ram_arbiter.sv
// Byte-wide RAM/IO bus sequencer shared by the IF fill port and the MEM load/store port.
// Build option ARB_ROUND_ROBIN_EN: simultaneous requests alternate instead of MEM-first.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_BUS,
   parameter int DATA_W = MEM_DATA_BUS
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_discard,
   output logic              ram_rw,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_w_data,
   input  logic [7:0]        ram_r_data,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_busy,
   output logic              if_ready,
   output logic [DATA_W-1:0] if_data,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic [2:0]        mem_length,
   input  logic              mem_signed,
   output logic              mem_busy,
   output logic              mem_ready,
   output logic [DATA_W-1:0] mem_data_o
);

   arb_state_t        state;
   logic [2:0]        cnt;
   logic [2:0]        len;
   logic [ADDR_W-1:0] base;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              sgn;
   logic              owner;
   logic              is_write;
   logic              mem_req;
   logic              if_req_ok;
   logic              if_pri;
   logic              grant_mem;
   logic              grant_if;
   logic [1:0]        lane;
   logic [DATA_W-1:0] ext_data;

   assign mem_req   = mem_read | mem_write;
   assign if_req_ok = if_req & ~if_discard;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_owner;

   // remember who was served last so a tie goes to the other side
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_owner <= OWNER_MEM;
      end else if (state == ST_IDLE && grant_mem) begin
         last_owner <= OWNER_MEM;
      end else if (state == ST_IDLE && grant_if) begin
         last_owner <= OWNER_IF;
      end else begin
         last_owner <= last_owner;
      end
   end

   assign if_pri = (last_owner == OWNER_MEM);
`else
   assign if_pri = 1'b0;
`endif

   assign grant_mem = mem_req & ~(if_pri & if_req_ok);
   assign grant_if  = if_req_ok & ~grant_mem;

   assign if_busy  = (state != ST_IDLE) | (mem_req & ~if_pri);
   assign mem_busy = (state != ST_IDLE);

   // lane that the byte currently on ram_r_data belongs to
   always_comb begin
      lane = 2'(cnt - 3'd1);
   end

   ram_arbiter_extend #(.DATA_W(DATA_W)) u_extend (
      .raw    (rdata),
      .len    (len),
      .sgn    (sgn),
      .result (ext_data)
   );

   // bus sequencer: grant, byte transfers, assembly and ready pulse
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= 3'd0;
         len        <= LEN_W;
         base       <= '0;
         wdata      <= '0;
         rdata      <= '0;
         sgn        <= 1'b0;
         owner      <= OWNER_MEM;
         is_write   <= 1'b0;
         ram_rw     <= 1'b0;
         ram_addr   <= '0;
         ram_w_data <= 8'h00;
         if_ready   <= 1'b0;
         if_data    <= '0;
         mem_ready  <= 1'b0;
         mem_data_o <= '0;
      end else begin
         ram_rw    <= 1'b0;
         if_ready  <= 1'b0;
         mem_ready <= 1'b0;
         case (state)
            ST_IDLE: begin
               cnt <= 3'd0;
               if (grant_mem) begin
                  base     <= mem_addr;
                  len      <= norm_len(mem_length);
                  sgn      <= mem_signed;
                  wdata    <= mem_data_i;
                  owner    <= OWNER_MEM;
                  is_write <= mem_write;
                  state    <= mem_write ? ST_MEM_WR : ST_MEM_RD;
               end else if (grant_if) begin
                  base     <= if_addr;
                  len      <= LEN_W;
                  sgn      <= 1'b0;
                  owner    <= OWNER_IF;
                  is_write <= 1'b0;
                  state    <= ST_IF_RD;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_IF_RD, ST_MEM_RD: begin
               if (state == ST_IF_RD && if_discard) begin
                  state <= ST_IDLE;
               end else begin
                  if (cnt < len) begin
                     ram_addr <= base + ADDR_W'(cnt);
                     cnt      <= cnt + 3'd1;
                  end
                  if (cnt != 3'd0) begin
                     rdata[{lane, 3'b000} +: 8] <= ram_r_data;
                  end
                  // the last address was driven one cycle ago; its byte lands now
                  if (cnt == len) begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_MEM_WR: begin
               ram_rw     <= 1'b1;
               ram_addr   <= base + ADDR_W'(cnt);
               ram_w_data <= wdata[{cnt[1:0], 3'b000} +: 8];
               cnt        <= cnt + 3'd1;
               if (cnt + 3'd1 == len) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (owner == OWNER_IF) begin
                  if (!if_discard) begin
                     if_ready <= 1'b1;
                     if_data  <= rdata;
                  end
               end else begin
                  mem_ready <= 1'b1;
                  if (!is_write) begin
                     mem_data_o <= ext_data;
                  end
               end
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
